fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-low reset (0 = reset, sampled on clk rising edge).
REQ-004 SHALL have port imem_req, output, 1, fetch request strobe, valid for one cycle per request.
REQ-005 SHALL have port imem_addr, output, 32, byte address of the request, valid while imem_req=1.
REQ-006 SHALL have port imem_rvalid, input, 1, instruction-memory response strobe, at least 1 cycle after imem_req.
REQ-007 SHALL have port imem_rdata, input, 32, response instruction word, valid while imem_rvalid=1.
REQ-008 SHALL have port redirect, input, 1, taken branch or jump from the datapath PC-select logic.
REQ-009 SHALL have port redirect_pc, input, 32, new fetch address, valid while redirect=1.
REQ-010 SHALL have port inst_valid, output, 1, buffer head holds a valid instruction.
REQ-011 SHALL have port inst_ready, input, 1, datapath consumes head when inst_valid=1.
REQ-012 SHALL have port inst, output, 32, head instruction word.
REQ-013 SHALL have port inst_pc, output, 32, address of head instruction.
REQ-014 SHALL have port inst_pc4, output, 32, inst_pc+4, modulo 2^32.
REQ-015 SHALL have port fetch_fault, output, 1, misaligned-redirect flag (see Configuration).

Function
REQ-016 SHALL hold a 2-entry FIFO of {instruction, pc}, with count 0..2.
REQ-017 SHALL implement states IDLE (no request outstanding), WAIT (one request outstanding) and FLUSH (outstanding response to be discarded).
REQ-018 SHALL drive imem_req=1 combinationally only when state=IDLE, count<2, redirect=0 and fetch_fault=0; imem_addr SHALL equal fetch_pc.
REQ-019 SHALL, on an issue edge, advance fetch_pc by 4 (wrapping at 2^32) and go to WAIT.
REQ-020 SHALL, in WAIT with imem_rvalid=1 and redirect=0, push {imem_rdata, address of the request} and go to IDLE; inst_valid rises the next cycle.
REQ-021 SHALL keep at most one request outstanding; count plus outstanding requests never exceeds 2.
REQ-022 SHALL pop the head on an edge where inst_valid=1 and inst_ready=1; push and pop in the same cycle leave count unchanged.
REQ-023 SHALL give redirect priority over push, pop and issue: FIFO emptied, fetch_pc set to redirect_pc, inst_valid=0 the next cycle.
REQ-024 SHALL, on redirect in WAIT without imem_rvalid, go to FLUSH; in FLUSH the next imem_rvalid is discarded and the state returns to IDLE.
REQ-025 SHALL, on redirect in WAIT with imem_rvalid in the same cycle, discard the response and go to IDLE.
REQ-026 SHALL, on redirect in FLUSH, stay in FLUSH and adopt the new redirect_pc.
REQ-027 SHALL ignore imem_rvalid in IDLE.
REQ-028 SHALL keep inst, inst_pc and inst_pc4 stable while inst_valid=1 and inst_ready=0.

Reset
REQ-029 SHALL, while reset=0 at a clk edge, set state=IDLE, count=0, fetch_pc=RESET_PC and fetch_fault=0; this aborts any outstanding request, whose response SHALL be ignored.
REQ-030 SHALL drive imem_req=0, inst_valid=0 and fetch_fault=0 during reset; the first imem_req occurs in the first cycle after reset=1 is sampled.

Configuration
REQ-031 SHALL use macro FETCH_MISALIGN_CHECK_EN. When defined, a redirect with redirect_pc[1:0]!=0 SHALL set fetch_fault=1, sticky until reset, still flush the FIFO, and stop all further issue. When undefined, redirect_pc[1:0] SHALL be forced to 0 and fetch_fault SHALL be tied to 0.

Verification
REQ-032 SHALL cover reset release with a 1-cycle-latency memory and inst_ready=1 -> imem_addr 0,4,8; inst_pc 0,4,8; inst_pc4 4,8,12.
REQ-033 SHALL cover inst_ready=0 with an always-ready memory -> exactly two requests (0,4), count=2, imem_req held 0, inst stays the word at 0.
REQ-034 SHALL cover redirect to 0x100 while WAIT on address 8, with the response arriving 2 cycles later -> that response is dropped and the next inst_pc=0x100.
REQ-035 SHALL cover redirect coincident with imem_rvalid -> the response is dropped, inst_valid=0 the next cycle, and the next imem_addr=redirect_pc.
REQ-036 SHALL cover redirect_pc=0x102 -> with FETCH_MISALIGN_CHECK_EN, fetch_fault=1 and no further imem_req until reset; without it, imem_addr=0x100.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues single outstanding fetches and buffers up to two {inst, pc} pairs.
// Latency: request combinational from IDLE; memory response is visible at inst_* the cycle after it returns.
// Backpressure: inst_ready=0 holds the head stable; issue stops while the 2-entry buffer plus in-flight fetch is full.
//
// Ports:
//   clk, reset          - single clock, synchronous active-low reset
//   imem_req/imem_addr  - fetch request strobe and byte address (one cycle per request)
//   imem_rvalid/rdata   - memory response strobe and instruction word
//   redirect/_pc        - taken branch/jump; flushes buffer and restarts fetch at redirect_pc
//   inst_valid/ready    - head-of-buffer handshake; inst, inst_pc, inst_pc4 describe the head
//   fetch_fault         - sticky misaligned-redirect flag
//
// Optional feature: define FETCH_MISALIGN_CHECK_EN to flag misaligned redirects and halt fetch.
// When undefined, the low two bits of redirect_pc are cleared and fetch_fault is always 0.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc4,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] fetch_pc;
    logic [31:0] req_pc;
    logic        run_q;
    logic [1:0]  count;
    logic        rd_ptr;
    logic        wr_ptr;
    logic [31:0] inst_q [2];
    logic [31:0] pc_q   [2];
    logic [31:0] redir_pc_eff;
    logic        fault_q;
    logic        issue;
    logic        push;
    logic        pop;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign redir_pc_eff = redirect_pc;

    // Once set, only reset clears the fault; it also blocks every later issue.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fault_q <= 1'b0;
        end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            fault_q <= 1'b1;
        end
    end
`else
    assign redir_pc_eff = redirect_pc & 32'hFFFF_FFFC;
    assign fault_q      = 1'b0;
`endif

    // run_q keeps requests off until reset=1 has actually been sampled.
    assign issue      = run_q && (state == IDLE) && (count < 2'd2) && !redirect && !fault_q;
    assign push       = (state == WAIT) && imem_rvalid && !redirect;
    assign inst_valid = (count != 2'd0);
    assign pop        = inst_valid && inst_ready && !redirect;

    assign imem_req    = issue;
    assign imem_addr   = fetch_pc;
    assign fetch_fault = fault_q;
    assign inst        = inst_q[rd_ptr];
    assign inst_pc     = pc_q[rd_ptr];
    assign inst_pc4    = inst_pc + 32'd4;

    // A response that arrives together with a redirect ends the outstanding
    // fetch (dropped), so WAIT goes straight to IDLE in that case.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue)       state_nxt = WAIT;
            WAIT: begin
                if (imem_rvalid)      state_nxt = IDLE;
                else if (redirect)    state_nxt = FLUSH;
            end
            FLUSH:   if (imem_rvalid) state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            run_q    <= 1'b0;
        end else begin
            run_q <= 1'b1;
            state <= state_nxt;
            if (redirect) begin
                fetch_pc <= redir_pc_eff;
                count    <= 2'd0;
                rd_ptr   <= 1'b0;
                wr_ptr   <= 1'b0;
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    req_pc   <= fetch_pc;
                end
                if (push) wr_ptr <= ~wr_ptr;
                if (pop)  rd_ptr <= ~rd_ptr;
                case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Buffer storage needs no reset; count qualifies every entry.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_q[wr_ptr] <= imem_rdata;
            pc_q[wr_ptr]   <= req_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;
    logic        fetch_fault;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory model state: one outstanding fetch, fixed latency in cycles.
    int          mem_lat = 1;
    logic        pend    = 1'b0;
    logic [31:0] paddr   = 32'h0;
    int          pcnt    = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_pc4    (inst_pc4),
        .fetch_fault (fetch_fault)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // Requests are seen mid-cycle; the response strobe covers the edge that
    // ends cycle (request + mem_lat).
    always @(negedge clk) begin
        imem_rvalid = 1'b0;
        if (reset !== 1'b1) pend = 1'b0;
        if (pend) begin
            pcnt = pcnt - 1;
            if (pcnt <= 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = word_at(paddr);
                pend        = 1'b0;
            end
        end
        if (imem_req === 1'b1) begin
            pend  = 1'b1;
            paddr = imem_addr;
            pcnt  = mem_lat;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Returns at 1 time unit after the edge that first samples reset=1.
    task automatic do_reset();
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        inst_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        inst_ready  = 1'b0;
        mem_lat     = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b expected 0", imem_req); end
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", inst_valid); end
        n_checks++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault: got %b expected 0", fetch_fault); end
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req_unsampled: got %b expected 0", imem_req); end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rst_first_req: got %b expected 1", imem_req); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_first_addr: got %h expected 00000000", imem_addr); end
    endtask

    task automatic test_stream();
        logic [31:0] a_seen[$];
        logic [31:0] p_seen[$];
        logic [31:0] p4_seen[$];
        logic [31:0] i_seen[$];
        int first_valid;
        logic [31:0] e;
        first_valid = -1;
        do_reset();
        inst_ready = 1'b1;
        mem_lat    = 1;
        for (int c = 0; c < 30 && p_seen.size() < 3; c++) begin
            @(negedge clk);
            if (imem_req) a_seen.push_back(imem_addr);
            if (inst_valid && first_valid < 0) first_valid = c;
            if (inst_valid && inst_ready) begin
                p_seen.push_back(inst_pc);
                p4_seen.push_back(inst_pc4);
                i_seen.push_back(inst);
            end
        end
        n_checks++; if (first_valid != 2) begin n_fail++; $display("FAIL stream_first_valid_cycle: got %0d expected 2", first_valid); end
        n_checks++;
        if (p_seen.size() < 3 || a_seen.size() < 3) begin
            n_fail++; $display("FAIL stream_timeout: got %0d pops %0d reqs expected 3 each", p_seen.size(), a_seen.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                e = 32'(4 * k);
                n_checks++; if (a_seen[k] !== e) begin n_fail++; $display("FAIL stream_addr%0d: got %h expected %h", k, a_seen[k], e); end
                n_checks++; if (p_seen[k] !== e) begin n_fail++; $display("FAIL stream_pc%0d: got %h expected %h", k, p_seen[k], e); end
                n_checks++; if (p4_seen[k] !== e + 32'd4) begin n_fail++; $display("FAIL stream_pc4_%0d: got %h expected %h", k, p4_seen[k], e + 32'd4); end
                n_checks++; if (i_seen[k] !== word_at(e)) begin n_fail++; $display("FAIL stream_inst%0d: got %h expected %h", k, i_seen[k], word_at(e)); end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] a_seen[$];
        do_reset();
        inst_ready = 1'b0;
        mem_lat    = 1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (imem_req) a_seen.push_back(imem_addr);
        end
        n_checks++; if (a_seen.size() != 2) begin n_fail++; $display("FAIL stall_nreq: got %0d expected 2", a_seen.size()); end
        if (a_seen.size() >= 2) begin
            n_checks++; if (a_seen[0] !== 32'h0) begin n_fail++; $display("FAIL stall_addr0: got %h expected 00000000", a_seen[0]); end
            n_checks++; if (a_seen[1] !== 32'h4) begin n_fail++; $display("FAIL stall_addr1: got %h expected 00000004", a_seen[1]); end
        end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req_held: got %b expected 0", imem_req); end
        n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %b expected 1", inst_valid); end
        n_checks++; if (inst !== word_at(32'h0)) begin n_fail++; $display("FAIL stall_inst: got %h expected %h", inst, word_at(32'h0)); end
        n_checks++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL stall_pc: got %h expected 00000000", inst_pc); end
        @(posedge clk);
        #1 inst_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL stall_pop0_pc: got %h expected 00000000", inst_pc); end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4) begin n_fail++; $display("FAIL stall_pop1: got valid %b pc %h expected valid 1 pc 00000004", inst_valid, inst_pc); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_fail++; $display("FAIL stall_resume: got req %b addr %h expected req 1 addr 00000008", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_wait();
        bit found;
        bit got;
        found = 1'b0;
        got   = 1'b0;
        do_reset();
        inst_ready = 1'b1;
        mem_lat    = 3;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 32'h8) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL rdw_timeout: got no request to 00000008 expected one");
        end else begin
            @(posedge clk);
            #1 redirect = 1'b1; redirect_pc = 32'h100;
            @(negedge clk);
            n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rdw_req_on_redirect: got %b expected 0", imem_req); end
            @(posedge clk);
            #1 redirect = 1'b0;
            @(negedge clk);
            n_checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL rdw_flush1: got valid %b req %b expected 0 0", inst_valid, imem_req); end
            @(posedge clk);
            #1;
            @(negedge clk);
            n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rdw_flush2_req: got %b expected 0", imem_req); end
            @(posedge clk);
            #1;
            @(negedge clk);
            n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_dropped: got valid %b expected 0", inst_valid); end
            n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL rdw_new_req: got req %b addr %h expected req 1 addr 00000100", imem_req, imem_addr); end
            for (int c = 0; c < 10 && !got; c++) begin
                @(negedge clk);
                if (inst_valid) got = 1'b1;
            end
            n_checks++;
            if (!got) begin
                n_fail++; $display("FAIL rdw_inst_timeout: got no valid inst expected one");
            end else begin
                n_checks++; if (inst_pc !== 32'h100) begin n_fail++; $display("FAIL rdw_inst_pc: got %h expected 00000100", inst_pc); end
                n_checks++; if (inst !== word_at(32'h100)) begin n_fail++; $display("FAIL rdw_inst: got %h expected %h", inst, word_at(32'h100)); end
            end
        end
    endtask

    task automatic test_redirect_rvalid();
        bit found;
        bit got;
        found = 1'b0;
        got   = 1'b0;
        do_reset();
        inst_ready = 1'b0;
        mem_lat    = 1;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 32'h4) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL rdr_timeout: got no request to 00000004 expected one");
        end else begin
            @(posedge clk);
            #1 redirect = 1'b1; redirect_pc = 32'h200;
            @(negedge clk);
            n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL rdr_head_before: got %b expected 1", inst_valid); end
            @(posedge clk);
            #1 redirect = 1'b0;
            @(negedge clk);
            n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rdr_valid_after: got %b expected 0", inst_valid); end
            n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_fail++; $display("FAIL rdr_new_req: got req %b addr %h expected req 1 addr 00000200", imem_req, imem_addr); end
            @(posedge clk);
            #1 inst_ready = 1'b1;
            for (int c = 0; c < 10 && !got; c++) begin
                @(negedge clk);
                if (inst_valid) got = 1'b1;
            end
            n_checks++;
            if (!got) begin
                n_fail++; $display("FAIL rdr_inst_timeout: got no valid inst expected one");
            end else begin
                n_checks++; if (inst_pc !== 32'h200 || inst !== word_at(32'h200)) begin n_fail++; $display("FAIL rdr_inst: got pc %h inst %h expected pc 00000200 inst %h", inst_pc, inst, word_at(32'h200)); end
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        inst_ready  = 1'b0;
        mem_lat     = 1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL wrap_req_on_redirect: got %b expected 0", imem_req); end
        @(posedge clk);
        #1 redirect = 1'b0;
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_req: got req %b addr %h expected req 1 addr fffffffc", imem_req, imem_addr); end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_head: got valid %b pc %h expected valid 1 pc fffffffc", inst_valid, inst_pc); end
        n_checks++; if (inst_pc4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4: got %h expected 00000000", inst_pc4); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next_addr: got req %b addr %h expected req 1 addr 00000000", imem_req, imem_addr); end
    endtask

    task automatic test_misalign();
        bit found;
        int nreq;
        found = 1'b0;
        nreq  = 0;
        do_reset();
        inst_ready = 1'b1;
        mem_lat    = 1;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 32'h4) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL mis_timeout: got no request to 00000004 expected one");
        end else begin
            @(posedge clk);
            #1 redirect = 1'b1; redirect_pc = 32'h102;
            @(negedge clk);
            @(posedge clk);
            #1 redirect = 1'b0;
            @(negedge clk);
`ifdef FETCH_MISALIGN_CHECK_EN
            n_checks++; if (fetch_fault !== 1'b1) begin n_fail++; $display("FAIL mis_fault_set: got %b expected 1", fetch_fault); end
            n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL mis_flush: got valid %b expected 0", inst_valid); end
            for (int c = 0; c < 8; c++) begin
                if (imem_req) nreq++;
                @(negedge clk);
            end
            n_checks++; if (nreq != 0) begin n_fail++; $display("FAIL mis_no_issue: got %0d requests expected 0", nreq); end
            n_checks++; if (fetch_fault !== 1'b1) begin n_fail++; $display("FAIL mis_fault_sticky: got %b expected 1", fetch_fault); end
            do_reset();
            @(negedge clk);
            n_checks++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL mis_fault_cleared: got %b expected 0", fetch_fault); end
            n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL mis_resume: got req %b addr %h expected req 1 addr 00000000", imem_req, imem_addr); end
`else
            n_checks++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL mis_fault_tied: got %b expected 0", fetch_fault); end
            n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL mis_aligned_addr: got req %b addr %h expected req 1 addr 00000100", imem_req, imem_addr); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_rvalid();
        test_wrap();
        test_misalign();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
